// File: rtl/reg_trace_buf.sv
// Register trace buffer: samples NCH channels periodically or on change,
// queues (channel, value, timestamp) records into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en, mode, period  capture enable, 0=periodic/1=on-change, interval-1
//   ch_data           packed channel inputs, channel i at [i*DW +: DW]
//   rd_en             pop request
//   rd_valid, rd_ch, rd_data, rd_ts   head entry of the FIFO
//   count             FIFO occupancy
//   busy              capture engine not idle
//   overflow          sticky: some event was lost
//   drop_cnt          saturating count of lost events
module reg_trace_buf #(
    parameter int NCH   = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 16,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [7:0]        period,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [CHW-1:0]    rd_ch,
    output logic [DW-1:0]     rd_data,
    output logic [TSW-1:0]    rd_ts,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nx;
    logic [TSW-1:0]   ts;
    logic [8:0]       ivl;
    logic [NCH-1:0]   pend;
    logic [DW-1:0]    last_val [NCH];
    logic [DW-1:0]    pend_val [NCH];
    logic [TSW-1:0]   pend_ts  [NCH];

    logic [CHW-1:0]   mem_ch [DEPTH];
    logic [DW-1:0]    mem_d  [DEPTH];
    logic [TSW-1:0]   mem_ts [DEPTH];
    logic [CW-1:0]    wptr, rptr;

    logic             arm, run, active, fire;
    logic [NCH-1:0]   ev, clr, ovw;
    logic [CHW-1:0]   sel;
    logic             has_sel, full, pop, push, full_drop;
    logic [16:0]      ndrop, dsum;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = DRAIN;
            DRAIN: begin
                if (en)               state_nx = RUN;
                else if (pend == '0)  state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign arm    = (state == IDLE) && en;
    assign run    = (state == RUN);
    assign active = (state != IDLE);
    assign busy   = active;
    // Down-counter reaches zero once per period+1 RUN cycles; the arm
    // snapshot occupies the first slot, so it is preloaded with period+1.
    assign fire   = run && !mode && (ivl == 9'd0);

    assign count    = wptr - rptr;
    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign has_sel  = active && (pend != '0);
    assign push     = has_sel && (!full || pop);
    assign full_drop = has_sel && full && !pop;

    always_comb begin
        ev    = '0;
        clr   = '0;
        ovw   = '0;
        sel   = '0;
        ndrop = {16'd0, full_drop};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) sel = CHW'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            ev[i]  = arm || (run && (mode ? (ch_data[i*DW +: DW] != last_val[i])
                                          : fire));
            clr[i] = has_sel && (sel == CHW'(i));
            // A pending slot being pushed this edge is not lost.
            ovw[i] = ev[i] && pend[i] && !clr[i];
            ndrop  = ndrop + 17'(ovw[i]);
        end
        dsum = {1'b0, drop_cnt} + ndrop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ts       <= '0;
            ivl      <= '0;
            pend     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            if (arm)      ts <= '0;
            else if (run) ts <= ts + 1'b1;
            if (arm)
                ivl <= {1'b0, period} + 9'd1;
            else if (run)
                ivl <= (ivl == 9'd0) ? {1'b0, period} : ivl - 9'd1;
            for (int i = 0; i < NCH; i++) begin
                if (ev[i])       pend[i] <= 1'b1;
                else if (clr[i]) pend[i] <= 1'b0;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (arm)
                overflow <= 1'b0;
            else if (full_drop || (ovw != '0))
                overflow <= 1'b1;
            drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (ev[i]) begin
                pend_val[i] <= ch_data[i*DW +: DW];
                pend_ts[i]  <= arm ? '0 : ts;
            end
            if (arm || (run && mode))
                last_val[i] <= ch_data[i*DW +: DW];
        end
        if (push) begin
            mem_ch[wptr[AW-1:0]] <= sel;
            mem_d[wptr[AW-1:0]]  <= pend_val[sel];
            mem_ts[wptr[AW-1:0]] <= pend_ts[sel];
        end
    end

    assign rd_ch   = rd_valid ? mem_ch[rptr[AW-1:0]] : '0;
    assign rd_data = rd_valid ? mem_d[rptr[AW-1:0]]  : '0;
    assign rd_ts   = rd_valid ? mem_ts[rptr[AW-1:0]] : '0;

endmodule
